// File: rtl/psum_reader_pkg.sv
// psum_reader_pkg: shared types and helpers for the partial-sum read-side controller.
//   state_t     - controller FSM states
//   psum_addr_f - psum SRAM address of kernel index k, output pixel o
package psum_reader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    LAST = 2'd2,
    OUT  = 2'd3
  } state_t;

  // Kernel-index-major layout: every pass k wrote one contiguous run of num_o pixels.
  function automatic int unsigned psum_addr_f(input int unsigned k,
                                              input int unsigned o,
                                              input int unsigned num_o);
    return k * num_o + o;
  endfunction

endpackage

// File: rtl/psum_acc_lane.sv
// psum_acc_lane: one column of the psum reducer.
//   clk, reset : clock, synchronous active-high reset
//   clr        : zero the accumulator (start of a pixel)
//   en         : add psum into the accumulator
//   psum       : signed column psum from the SRAM word
//   relu       : registered ReLU of the accumulator
module psum_acc_lane #(
  parameter int bw = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  input  logic [bw-1:0] psum,
  output logic [bw-1:0] relu
);

  logic [bw-1:0] acc;
  logic [bw-1:0] acc_d;

  // Plain bw-bit add is two's-complement wrap-around, so no sign extension is needed.
  always_comb begin
    acc_d = acc;
    if (clr)
      acc_d = '0;
    else if (en)
      acc_d = acc + psum;
  end

  // ReLU is taken from acc_d so the output register is current in the same
  // cycle the final psum lands in the accumulator.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc  <= '0;
      relu <= '0;
    end else begin
      acc  <= acc_d;
      relu <= acc_d[bw-1] ? '0 : acc_d;
    end
  end

endmodule

// File: rtl/psum_reader.sv
// psum_reader: walks psum SRAM one output pixel at a time, sums num_kij psums per
// column, applies ReLU and presents the column vector on a valid/ready port.
//   clk, reset          : clock, synchronous active-high reset
//   start               : request a tile (sampled only while idle)
//   busy, done          : busy outside IDLE; done pulses after the last handshake
//   psum_cen, psum_wen  : SRAM enables, active-low (write never enabled)
//   psum_addr, psum_q   : SRAM read address / data (data one cycle after cen low)
//   out_data, out_valid, out_ready : downstream column-vector handshake
//
// state | meaning
// IDLE  | waiting for start
// READ  | issuing one SRAM read per cycle for k = 0..num_kij-1
// LAST  | no read; final psum of the pixel is being accumulated
// OUT   | holding the ReLU'd vector until out_ready
module psum_reader
  import psum_reader_pkg::*;
#(
  parameter int bw      = 16,
  parameter int col     = 8,
  parameter int num_kij = 9,
  parameter int num_o   = 16,
  parameter int addr_w  = 11
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                psum_cen,
  output logic                psum_wen,
  output logic [addr_w-1:0]   psum_addr,
  input  logic [bw*col-1:0]   psum_q,
  output logic [bw*col-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int kw = (num_kij > 1) ? $clog2(num_kij) : 1;
  localparam int ow = (num_o > 1) ? $clog2(num_o) : 1;

  state_t        state, state_d;
  logic [kw-1:0] k, k_d;
  logic [ow-1:0] o, o_d;
  logic          rd_pend;
  logic          clr;
  logic          done_d;

  always_comb begin
    state_d = state;
    k_d     = k;
    o_d     = o;
    clr     = 1'b0;
    done_d  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          k_d     = '0;
          o_d     = '0;
          clr     = 1'b1;
          state_d = READ;
        end
      end
      READ: begin
        if (k == kw'(num_kij - 1))
          state_d = LAST;
        else
          k_d = k + 1'b1;
      end
      LAST: state_d = OUT;
      OUT: begin
        if (out_ready) begin
          if (o == ow'(num_o - 1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            o_d     = o + 1'b1;
            k_d     = '0;
            clr     = 1'b1;
            state_d = READ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      k       <= '0;
      o       <= '0;
      rd_pend <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_d;
      k       <= k_d;
      o       <= o_d;
      rd_pend <= (state == READ);
      done    <= done_d;
    end
  end

  assign busy      = (state != IDLE);
  assign out_valid = (state == OUT);
  assign psum_cen  = (state != READ);
  assign psum_wen  = 1'b1;
  assign psum_addr = (state == READ) ? addr_w'(psum_addr_f(32'(k), 32'(o), 32'(num_o))) : '0;

  // rd_pend is low in IDLE and OUT, so clr and en never coincide.
  for (genvar i = 0; i < col; i++) begin : g_lane
    psum_acc_lane #(.bw(bw)) u_lane (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .en    (rd_pend),
      .psum  (psum_q[bw*i +: bw]),
      .relu  (out_data[bw*i +: bw])
    );
  end

endmodule

// File: tb/tb_psum_reader.sv
// tb_psum_reader: self-checking bench for psum_reader with an SRAM model and a
// behavioural reference (per-pixel modulo-2^16 column sums followed by ReLU).
module tb_psum_reader;

  localparam int BW  = 16;
  localparam int COL = 8;
  localparam int NK  = 9;
  localparam int NO  = 16;
  localparam int AW  = 11;
  localparam int W   = BW * COL;
  localparam int TILE = NO * (NK + 2);

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          busy;
  logic          done;
  logic          psum_cen;
  logic          psum_wen;
  logic [AW-1:0] psum_addr;
  logic [W-1:0]  psum_q;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [W-1:0] mem [0:(1<<AW)-1];
  int unsigned  rd_q[$];
  logic [W-1:0] got_q[$];
  int done_edge, first_valid_edge, stall_cycles, stall_bad;

  psum_reader #(.bw(BW), .col(COL), .num_kij(NK), .num_o(NO), .addr_w(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .psum_cen  (psum_cen),
    .psum_wen  (psum_wen),
    .psum_addr (psum_addr),
    .psum_q    (psum_q),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // SRAM: read data appears one cycle after the cycle with cen low.
  always @(posedge clk) begin
    if (!psum_cen) psum_q <= mem[psum_addr];
    if (!reset && !psum_cen) rd_q.push_back(int'(psum_addr));
  end

  function automatic logic [W-1:0] model_pixel(input int o);
    logic [W-1:0] r;
    logic [W-1:0] word;
    logic [15:0]  t;
    int s;
    r = '0;
    for (int i = 0; i < COL; i++) begin
      s = 0;
      for (int k = 0; k < NK; k++) begin
        word = mem[k*NO + o];
        s = s + int'($signed(word[BW*i +: BW]));
      end
      t = s[15:0];
      r[BW*i +: BW] = t[15] ? 16'h0 : t;
    end
    return r;
  endfunction

  task automatic fill_random();
    for (int a = 0; a < (1<<AW); a++) mem[a] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // mode 0: always ready, 1: random ready, 2: stall the first 5 valid cycles.
  task automatic run_tile(input int mode, input int extra_start);
    int n;
    int stall_left;
    bit was_stalled;
    logic [W-1:0] held;
    got_q.delete();
    rd_q.delete();
    done_edge = -1; first_valid_edge = -1; stall_cycles = 0; stall_bad = 0;
    stall_left = (mode == 2) ? 5 : 0;
    was_stalled = 0;
    held = '0;
    @(negedge clk);
    start = 1'b1;
    out_ready = (mode == 0);
    @(posedge clk);
    n = 0;
    @(negedge clk);
    start = 1'b0;
    while (done_edge < 0 && n < 3000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start = (n == extra_start);
      if (done) done_edge = n;
      if (out_valid && first_valid_edge < 0) first_valid_edge = n;
      if (out_valid) begin
        if (was_stalled && out_data !== held) stall_bad++;
        case (mode)
          1:       out_ready = ($urandom_range(0, 3) != 0);
          2:       out_ready = (stall_left == 0);
          default: out_ready = 1'b1;
        endcase
        if (!out_ready) begin
          stall_cycles++;
          if (!psum_cen) stall_bad++;
          if (stall_left > 0) stall_left--;
          held = out_data;
          was_stalled = 1;
        end else begin
          got_q.push_back(out_data);
          was_stalled = 0;
        end
      end else begin
        out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        was_stalled = 0;
      end
    end
    start = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++; if (busy !== 1'b0)      begin tests_failed++; $display("FAIL reset_busy got %0b exp 0", busy); end
    tests_run++; if (done !== 1'b0)      begin tests_failed++; $display("FAIL reset_done got %0b exp 0", done); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
    tests_run++; if (out_data !== '0)    begin tests_failed++; $display("FAIL reset_data got %h exp 0", out_data); end
    tests_run++; if (psum_cen !== 1'b1)  begin tests_failed++; $display("FAIL reset_cen got %0b exp 1", psum_cen); end
    tests_run++; if (psum_wen !== 1'b1)  begin tests_failed++; $display("FAIL reset_wen got %0b exp 1", psum_wen); end
    tests_run++; if (psum_addr !== '0)   begin tests_failed++; $display("FAIL reset_addr got %0d exp 0", psum_addr); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++; if (busy !== 1'b0)      begin tests_failed++; $display("FAIL idle_no_start got busy %0b exp 0", busy); end
  endtask

  task automatic test_basic();
    for (int a = 0; a < (1<<AW); a++) mem[a] = {COL{16'h0001}};
    run_tile(0, 0);
    tests_run++; if (got_q.size() != NO) begin tests_failed++; $display("FAIL basic_count got %0d exp %0d", got_q.size(), NO); end
    for (int o = 0; o < NO && o < got_q.size(); o++) begin
      tests_run++;
      if (got_q[o] !== {COL{16'd9}}) begin tests_failed++; $display("FAIL basic_pix%0d got %h exp %h", o, got_q[o], {COL{16'd9}}); end
    end
    tests_run++; if (first_valid_edge != NK + 1) begin tests_failed++; $display("FAIL basic_latency got %0d exp %0d", first_valid_edge, NK + 1); end
    tests_run++; if (done_edge != TILE) begin tests_failed++; $display("FAIL basic_done got %0d exp %0d", done_edge, TILE); end
  endtask

  task automatic test_relu_wrap();
    logic [W-1:0] w;
    fill_random();
    for (int k = 0; k < NK; k++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      w[15:0]  = (k < 3) ? 16'h7FFF : 16'h0;
      w[31:16] = (k < 2) ? 16'h4000 : 16'h0;
      w[47:32] = (k == 0) ? 16'hFFFB : (k == 1) ? 16'd2 : (k == 2) ? 16'd1 : 16'd0;
      w[63:48] = (k == 0) ? 16'd5 : (k == 1) ? 16'hFFFE : (k == 2) ? 16'd1 : 16'd0;
      mem[k*NO] = w;
    end
    run_tile(0, 0);
    tests_run++; if (got_q.size() != NO) begin tests_failed++; $display("FAIL relu_count got %0d exp %0d", got_q.size(), NO); end
    if (got_q.size() > 0) begin
      w = got_q[0];
      tests_run++; if (w[15:0]  !== 16'h7FFD) begin tests_failed++; $display("FAIL wrap_7fff got %h exp 7ffd", w[15:0]); end
      tests_run++; if (w[31:16] !== 16'h0)    begin tests_failed++; $display("FAIL wrap_8000 got %h exp 0", w[31:16]); end
      tests_run++; if (w[47:32] !== 16'h0)    begin tests_failed++; $display("FAIL relu_neg got %h exp 0", w[47:32]); end
      tests_run++; if (w[63:48] !== 16'd4)    begin tests_failed++; $display("FAIL relu_pos got %h exp 4", w[63:48]); end
    end
    for (int o = 0; o < NO && o < got_q.size(); o++) begin
      tests_run++;
      if (got_q[o] !== model_pixel(o)) begin tests_failed++; $display("FAIL relu_pix%0d got %h exp %h", o, got_q[o], model_pixel(o)); end
    end
  endtask

  task automatic test_backpressure();
    fill_random();
    run_tile(2, 0);
    tests_run++; if (stall_cycles != 5) begin tests_failed++; $display("FAIL bp_stalls got %0d exp 5", stall_cycles); end
    tests_run++; if (stall_bad != 0)    begin tests_failed++; $display("FAIL bp_stable got %0d violations exp 0", stall_bad); end
    tests_run++; if (done_edge != TILE + 5) begin tests_failed++; $display("FAIL bp_done got %0d exp %0d", done_edge, TILE + 5); end
    tests_run++; if (got_q.size() != NO) begin tests_failed++; $display("FAIL bp_count got %0d exp %0d", got_q.size(), NO); end
    for (int o = 0; o < NO && o < got_q.size(); o++) begin
      tests_run++;
      if (got_q[o] !== model_pixel(o)) begin tests_failed++; $display("FAIL bp_pix%0d got %h exp %h", o, got_q[o], model_pixel(o)); end
    end
  endtask

  task automatic test_random_ready();
    fill_random();
    run_tile(1, 0);
    tests_run++; if (stall_bad != 0) begin tests_failed++; $display("FAIL rr_stable got %0d violations exp 0", stall_bad); end
    tests_run++; if (done_edge != TILE + stall_cycles) begin tests_failed++; $display("FAIL rr_done got %0d exp %0d", done_edge, TILE + stall_cycles); end
    tests_run++; if (got_q.size() != NO) begin tests_failed++; $display("FAIL rr_count got %0d exp %0d", got_q.size(), NO); end
    for (int o = 0; o < NO && o < got_q.size(); o++) begin
      tests_run++;
      if (got_q[o] !== model_pixel(o)) begin tests_failed++; $display("FAIL rr_pix%0d got %h exp %h", o, got_q[o], model_pixel(o)); end
    end
  endtask

  task automatic test_addr_order();
    int j;
    fill_random();
    run_tile(0, 30);
    tests_run++; if (rd_q.size() != NK * NO) begin tests_failed++; $display("FAIL addr_count got %0d exp %0d", rd_q.size(), NK * NO); end
    for (int o = 0; o < NO; o++)
      for (int k = 0; k < NK; k++) begin
        j = o * NK + k;
        if (j < rd_q.size()) begin
          tests_run++;
          if (rd_q[j] != k * NO + o) begin tests_failed++; $display("FAIL addr_seq%0d got %0d exp %0d", j, rd_q[j], k * NO + o); end
        end
      end
    tests_run++; if (done_edge != TILE) begin tests_failed++; $display("FAIL busy_start_done got %0d exp %0d", done_edge, TILE); end
    repeat (3) @(negedge clk);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL busy_start_idle got busy %0b exp 0", busy); end
  endtask

  task automatic test_reset_mid();
    int seen;
    fill_random();
    @(negedge clk);
    start = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    tests_run++; if (psum_addr !== AW'(4 * NO)) begin tests_failed++; $display("FAIL mid_addr_k4 got %0d exp %0d", psum_addr, 4 * NO); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests_run++; if (busy !== 1'b0)      begin tests_failed++; $display("FAIL mid_busy got %0b exp 0", busy); end
    tests_run++; if (psum_cen !== 1'b1)  begin tests_failed++; $display("FAIL mid_cen got %0b exp 1", psum_cen); end
    tests_run++; if (psum_addr !== '0)   begin tests_failed++; $display("FAIL mid_addr got %0d exp 0", psum_addr); end
    tests_run++; if (out_data !== '0)    begin tests_failed++; $display("FAIL mid_data got %h exp 0", out_data); end
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done || out_valid) seen++;
    end
    tests_run++; if (seen != 0) begin tests_failed++; $display("FAIL mid_no_output got %0d exp 0", seen); end
    run_tile(0, 0);
    tests_run++; if (done_edge != TILE) begin tests_failed++; $display("FAIL mid_restart_done got %0d exp %0d", done_edge, TILE); end
    tests_run++; if (got_q.size() != NO) begin tests_failed++; $display("FAIL mid_count got %0d exp %0d", got_q.size(), NO); end
    for (int o = 0; o < NO && o < got_q.size(); o++) begin
      tests_run++;
      if (got_q[o] !== model_pixel(o)) begin tests_failed++; $display("FAIL mid_pix%0d got %h exp %h", o, got_q[o], model_pixel(o)); end
    end
  endtask

  initial begin
    psum_q = '0;
    test_reset();
    test_basic();
    test_relu_wrap();
    test_backpressure();
    test_random_ready();
    test_addr_order();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
